trap_ctrl: RTL
==============

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter: XLEN, default 64, data/address width; matches the DATA_BUS and INST_ADDR_BUS widths.
REQ-002 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-low.
REQ-004 Port: commit_valid  in  1  an instruction is presented at commit.
REQ-005 Port: commit_pc  in  XLEN  PC of the presented instruction.
REQ-006 Port: commit_ecall / commit_ebreak / commit_mret  in  1 each  decode flags of the presented instruction.
REQ-007 Port: mstatus_mie, mie_mtie, mip_mtip  in  1 each  live CSR bits.
REQ-008 Port: mtvec, mepc  in  XLEN  live CSR values.
REQ-009 Port: redirect_ready  in  1  fetch accepts the redirect.
REQ-010 Port: stall  out  1  hold the commit stage; the presented instruction is not retired.
REQ-011 Port: csr_trap_we  out  1  one-cycle pulse that writes mepc/mcause and applies the mstatus trap update.
REQ-012 Port: csr_mepc_wdata, csr_mcause_wdata  out  XLEN  data for csr_trap_we.
REQ-013 Port: csr_mret_we  out  1  one-cycle pulse that applies the mstatus mret update.
REQ-014 Port: redirect_valid  out  1 / redirect_pc  out  XLEN  new fetch target.
REQ-015 Port: flush  out  1  one-cycle pulse that squashes younger pipeline state.

Function
REQ-016 FSM states: IDLE, TRAP_SAVE, MRET_RESTORE, REDIRECT.
REQ-017 irq_pend = mstatus_mie & mie_mtie & mip_mtip.
REQ-018 Event is accepted in IDLE when commit_valid and any of (irq_pend, ecall, ebreak, mret) is true.
REQ-019 Event priority: irq_pend > ecall > ebreak > mret.
REQ-020 Causes:
- interrupt: 2^(XLEN-1) + 7.
- ecall: 11.
- ebreak: 3.
REQ-021 On acceptance, the block latches commit_pc, the cause, and the target.
REQ-022 Trap target:
- mtvec[1:0]==1 and interrupt: (mtvec & ~3) + 4*7 (cause code 7), modulo 2^XLEN.
- otherwise: mtvec & ~3.
REQ-023 mret target: mepc sampled at acceptance.
REQ-024 Transitions:
- accepted trap: IDLE -> TRAP_SAVE.
- accepted mret: IDLE -> MRET_RESTORE.
- TRAP_SAVE or MRET_RESTORE -> REDIRECT after one cycle.
- REDIRECT -> IDLE on redirect_valid & redirect_ready.
REQ-025 stall is combinationally 1 in the acceptance cycle and 1 in every non-IDLE state; otherwise 0.
REQ-026 csr_trap_we = 1 only in TRAP_SAVE, with csr_mepc_wdata = latched PC and csr_mcause_wdata = latched cause.
REQ-027 csr_mret_we = 1 only in MRET_RESTORE.
REQ-028 Latency: from the acceptance cycle N, the CSR pulse occurs in N+1 and redirect_valid rises in N+2.
REQ-029 redirect_valid and redirect_pc remain stable until the handshake, for any length of backpressure.
REQ-030 flush pulses in the cycle after the handshake, concurrent with the return to IDLE; a new event is acceptable in that same cycle.
REQ-031 commit_valid and all event inputs are ignored outside IDLE.
REQ-032 The interrupt is taken only at an instruction boundary: mepc = PC of the unretired instruction.
REQ-033 An interrupt that coincides with ecall/ebreak/mret wins; the instruction is re-presented after the handler.
REQ-034 mip_mtip deasserting after acceptance has no effect on the sequence.

Reset
REQ-035 While rst=0 at a clock edge: state -> IDLE and all latches -> 0.
REQ-036 During and after reset, all outputs = 0, including redirect_pc and the wdata outputs.
REQ-037 Reset mid-sequence aborts it: no pending pulse, redirect or flush is emitted after reset.

Structure
REQ-038 The state encoding, cause constants (CAUSE_MTI, CAUSE_ECALL_M=11, CAUSE_BREAK=3) and the vector offset constant belong in the shared definitions package.
REQ-039 One combinational sub-module, trap_prio, SHALL contain the priority select, cause and target computation; trap_ctrl holds the FSM and latches.

Verification
REQ-040 ecall at PC 0x8000_0010, mtvec=0x8000_1001, redirect_ready=1 -> N+1: csr_trap_we with mepc=0x8000_0010 and mcause=11; N+2: redirect_pc=0x8000_1000; N+3: flush.
REQ-041 irq_pend=1 with ecall at PC 0x100 and mtvec=0x2001 -> mcause=0x8000_0000_0000_0007, mepc=0x100, redirect_pc=0x201C.
REQ-042 mret with mepc=0x8000_0040 and redirect_ready held low for 5 cycles -> csr_mret_we one cycle; redirect_valid high for 6 cycles with redirect_pc stable at 0x8000_0040; one flush.
REQ-043 ebreak accepted, rst=0 asserted in TRAP_SAVE -> no csr_trap_we, redirect_valid or flush; all outputs 0 on the following cycles.
REQ-044 Back-to-back: ecall accepted in the flush cycle of a prior trap -> second TRAP_SAVE in the next cycle with no dropped event; toggling commit_* in REDIRECT -> no effect.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap/mret sequencer: state encoding,
// exception cause codes and the vectored-interrupt offset.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_TRAP_SAVE    = 2'd1,
        ST_MRET_RESTORE = 2'd2,
        ST_REDIRECT     = 2'd3
    } state_t;

    // Cause codes without the interrupt bit; the MSB is added for CAUSE_MTI.
    localparam int unsigned CAUSE_MTI      = 32'd7;
    localparam int unsigned CAUSE_ECALL_M  = 32'd11;
    localparam int unsigned CAUSE_BREAK    = 32'd3;
    localparam int unsigned VEC_OFFSET_MTI = 32'd4 * CAUSE_MTI;

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_prio.sv
// Combinational event arbiter: picks the highest-priority commit event and
// computes its mcause value and fetch target.
module trap_prio
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            commit_valid_i,
    input  logic            commit_ecall_i,
    input  logic            commit_ebreak_i,
    input  logic            commit_mret_i,
    input  logic            mstatus_mie_i,
    input  logic            mie_mtie_i,
    input  logic            mip_mtip_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            accept_o,
    output logic            is_mret_o,
    output logic [XLEN-1:0] cause_o,
    output logic [XLEN-1:0] target_o
);

    logic            irq_pend_s;
    logic [XLEN-1:0] base_s;

    // Priority select: timer interrupt, then ecall, ebreak, mret.
    always_comb begin
        irq_pend_s = mstatus_mie_i & mie_mtie_i & mip_mtip_i;
        accept_o   = commit_valid_i &
                     (irq_pend_s | commit_ecall_i | commit_ebreak_i | commit_mret_i);
        base_s     = {mtvec_i[XLEN-1:2], 2'b00};
        is_mret_o  = 1'b0;
        cause_o    = '0;
        target_o   = base_s;
        if (irq_pend_s) begin
            cause_o = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(CAUSE_MTI);
            if (mtvec_i[1:0] == MTVEC_VECTORED) begin
                target_o = base_s + XLEN'(VEC_OFFSET_MTI);
            end else begin
                target_o = base_s;
            end
        end else if (commit_ecall_i) begin
            cause_o = XLEN'(CAUSE_ECALL_M);
        end else if (commit_ebreak_i) begin
            cause_o = XLEN'(CAUSE_BREAK);
        end else if (commit_mret_i) begin
            is_mret_o = 1'b1;
            target_o  = mepc_i;
        end else begin
            is_mret_o = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Commit-stage trap controller: accepts interrupt/ecall/ebreak/mret, pulses the
// CSR update, holds a redirect until fetch accepts it, then flushes.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            commit_ecall,
    input  logic            commit_ebreak,
    input  logic            commit_mret,
    input  logic            mstatus_mie,
    input  logic            mie_mtie,
    input  logic            mip_mtip,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            redirect_ready,
    output logic            stall,
    output logic            csr_trap_we,
    output logic [XLEN-1:0] csr_mepc_wdata,
    output logic [XLEN-1:0] csr_mcause_wdata,
    output logic            csr_mret_we,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush
);

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] target_q;
    logic            trap_we_q;
    logic            mret_we_q;
    logic            redirect_valid_q;
    logic            flush_q;

    logic            accept_s;
    logic            is_mret_s;
    logic [XLEN-1:0] cause_s;
    logic [XLEN-1:0] target_s;

    trap_prio #(.XLEN(XLEN)) u_prio (
        .commit_valid_i  (commit_valid),
        .commit_ecall_i  (commit_ecall),
        .commit_ebreak_i (commit_ebreak),
        .commit_mret_i   (commit_mret),
        .mstatus_mie_i   (mstatus_mie),
        .mie_mtie_i      (mie_mtie),
        .mip_mtip_i      (mip_mtip),
        .mtvec_i         (mtvec),
        .mepc_i          (mepc),
        .accept_o        (accept_s),
        .is_mret_o       (is_mret_s),
        .cause_o         (cause_s),
        .target_o        (target_s)
    );

    // Sequencer FSM with latched event data and registered output pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            pc_q             <= '0;
            cause_q          <= '0;
            target_q         <= '0;
            trap_we_q        <= 1'b0;
            mret_we_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    flush_q <= 1'b0;
                    if (accept_s) begin
                        pc_q      <= commit_pc;
                        cause_q   <= cause_s;
                        target_q  <= target_s;
                        trap_we_q <= ~is_mret_s;
                        mret_we_q <= is_mret_s;
                        state_q   <= is_mret_s ? ST_MRET_RESTORE : ST_TRAP_SAVE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_TRAP_SAVE, ST_MRET_RESTORE: begin
                    trap_we_q        <= 1'b0;
                    mret_we_q        <= 1'b0;
                    redirect_valid_q <= 1'b1;
                    state_q          <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid_q <= 1'b0;
                        flush_q          <= 1'b1;
                        state_q          <= ST_IDLE;
                    end else begin
                        state_q <= ST_REDIRECT;
                    end
                end
                default: begin
                    state_q          <= ST_IDLE;
                    trap_we_q        <= 1'b0;
                    mret_we_q        <= 1'b0;
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                end
            endcase
        end
    end

    // Stall covers the acceptance cycle and the whole sequence; all outputs
    // are forced low while reset is held.
    always_comb begin
        if (state_q == ST_IDLE) begin
            stall = rst & accept_s;
        end else begin
            stall = rst;
        end
    end

    assign csr_trap_we      = rst & trap_we_q;
    assign csr_mret_we      = rst & mret_we_q;
    assign redirect_valid   = rst & redirect_valid_q;
    assign flush            = rst & flush_q;
    assign csr_mepc_wdata   = rst ? pc_q     : '0;
    assign csr_mcause_wdata = rst ? cause_q  : '0;
    assign redirect_pc      = rst ? target_q : '0;

endmodule
